// File: rtl/serial_right_shifter_pkg.sv
// Shared types and defaults for the serial right shifter.
package serial_right_shifter_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/serial_right_shifter_right_shift_by_one.sv
// One-bit right shift step: result = {fill, data[N-1:1]}.
module right_shift_by_one #(
    parameter int N = 8
) (
    input  logic [N-1:0] data,
    input  logic         fill,
    output logic [N-1:0] shifted
);

    always_comb begin
        shifted = (data >> 1) | ({{(N-1){1'b0}}, fill} << (N-1));
    end

endmodule

// File: rtl/serial_right_shifter.sv
// Multi-cycle right shifter, one bit per clock, valid/ready on both sides.
// Define SERIAL_RIGHT_SHIFTER_ARITH_EN to honour the arith (sign-fill) input.
module serial_right_shifter
    import serial_right_shifter_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arg_vld,
    output logic          arg_rdy,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] shamt,
    input  logic          arith,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [N-1:0]  res
);

    state_t        state_q, state_d;
    logic [N-1:0]  data_q, data_d, step;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          arith_sel;
    logic          fill;

    // Without the macro the fill mode register can only ever load 0.
`ifdef SERIAL_RIGHT_SHIFTER_ARITH_EN
    assign arith_sel = arith;
`else
    assign arith_sel = arith & 1'b0;
`endif

    assign fill = mode_q & data_q[N-1];

    right_shift_by_one #(.N(N)) u_step (
        .data    (data_q),
        .fill    (fill),
        .shifted (step)
    );

    assign arg_rdy = (state_q == IDLE);
    assign res_vld = (state_q == DONE);
    assign res     = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (arg_vld) begin
                    data_d  = a;
                    cnt_d   = shamt;
                    mode_d  = arith_sel;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Counts >= N keep stepping, naturally saturating to all-fill.
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    data_d = step;
                    cnt_d  = cnt_q - SW'(1);
                end
            end
            DONE: begin
                if (res_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/serial_right_shifter.md
SERIAL_RIGHT_SHIFTER -- requirements
Module: serial_right_shifter

Interface
REQ-001 SHALL have parameter N, default 8, meaning data width in bits (N >= 2).
REQ-002 SHALL have parameter SW, default $clog2(N), meaning shift-amount width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port arg_vld, input, 1, upstream operand valid.
REQ-006 SHALL have port arg_rdy, output, 1, block ready to accept an operand.
REQ-007 SHALL have port a, input, N, operand to shift, unsigned unless arith is honoured.
REQ-008 SHALL have port shamt, input, SW, right-shift amount.
REQ-009 SHALL have port arith, input, 1, 1 = arithmetic (sign-fill), 0 = logical (zero-fill).
REQ-010 SHALL have port res_vld, output, 1, result valid.
REQ-011 SHALL have port res_rdy, input, 1, downstream ready for the result.
REQ-012 SHALL have port res, output, N, shifted result.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 SHALL drive arg_rdy = 1 only in IDLE and res_vld = 1 only in DONE, both decoded combinationally from state.
REQ-015 SHALL, on an accept (arg_vld & arg_rdy at an edge), load data register <= a, count <= shamt and fill mode <= arith, and go IDLE -> SHIFT.
REQ-016 SHALL, in SHIFT with count != 0, shift the data register right by exactly one bit per cycle and decrement count.
REQ-017 SHALL fill the vacated MSB with 0 when logical and with the current data MSB when arithmetic.
REQ-018 SHALL go SHIFT -> DONE at the edge where count == 0, without shifting on that edge.
REQ-019 SHALL assert res_vld exactly shamt+1 cycles after the accept edge (shamt = 0 gives 1 cycle).
REQ-020 SHALL drive res from the data register and hold res stable throughout DONE while res_rdy = 0.
REQ-021 SHALL go DONE -> IDLE on res_vld & res_rdy; a new operand can be accepted no earlier than the following edge.
REQ-022 SHALL ignore arg_vld, a, shamt and arith outside IDLE; operands are latched only on accept.
REQ-023 SHALL, for shamt >= N (possible when N is not a power of two), return all-zeros when logical and all-sign-bits when arithmetic, with latency still shamt+1.
REQ-024 SHALL give, for logical mode, a result identical to a >> shamt in width N.

Reset
REQ-025 SHALL, while rst_n = 0 and asynchronously, force state = IDLE, data = 0, count = 0 and fill mode = 0, so that res = 0, res_vld = 0 and arg_rdy = 1.
REQ-026 SHALL, on reset asserted mid-SHIFT or mid-DONE, discard the operation with no result presented; the first accept is possible at the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL honour the arith input and sign-fill only when macro SERIAL_RIGHT_SHIFTER_ARITH_EN is defined.
REQ-028 SHALL keep the arith port present when the macro is undefined, but ignore it and always perform a logical shift.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, SHIFT, DONE) and the default width constant in package serial_right_shifter_pkg.
REQ-030 SHALL use one combinational sub-module, right_shift_by_one (inputs: data, fill bit; output: {fill, data[N-1:1]}), for the per-cycle step.

Verification
REQ-031 SHALL cover: reset; accept a=8'hB4, shamt=3, arith=0 -> res_vld 4 cycles after accept, res=8'h16.
REQ-032 SHALL cover, with the ARITH_EN macro defined: a=8'hB4, shamt=3, arith=1 -> res=8'hF6; with the macro undefined, same stimulus -> res=8'h16.
REQ-033 SHALL cover: shamt=0, a=8'h5A -> res_vld 1 cycle after accept, res=8'h5A.
REQ-034 SHALL cover: res_rdy held 0 for 5 cycles in DONE with arg_vld=1 and new a toggling -> res and res_vld stable, arg_rdy=0, nothing accepted.
REQ-035 SHALL cover: rst_n pulsed low during SHIFT of a=8'hFF, shamt=7 -> res_vld=0, res=0 immediately, arg_rdy=1; the next operation completes correctly.
REQ-036 SHALL cover: 200 random back-to-back operations with random res_rdy -> every res equals the model (a >> shamt, or sign-fill), in order, none lost or duplicated.
